regfile_sb: RTL and testbench

Parametrised MIPS general-purpose register file with two asynchronous read ports and two prioritised write ports, plus a per-register scoreboard that tracks outstanding long-latency results (loads, multiply/divide). It sits in the decode stage of the multi-cycle/pipelined CPU core. Issue logic claims a destination register; the register is cleared when its result returns on the late write port. The block provides optional write-first bypass and a registered count of outstanding claims.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_sb_sb_ctrl.sv | 111 +++++++++++
 rtl/regfile_sb.sv | 137 +++++++++++++
 tb/tb_regfile_sb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the decode-stage register file and its scoreboard.
//   - default data/address widths
//   - ZERO_ADDR: the hard-wired zero register address
//   - cnt_step_e / cnt_step(): one-step up/down decision for the busy counter,
//     so the outstanding-claim count never needs a popcount over the vector
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10
  } cnt_step_e;

  // A new busy bit and a retired busy bit in the same cycle cancel out.
  function automatic cnt_step_e cnt_step(input logic inc, input logic dec);
    cnt_step_e step;
    step = CNT_HOLD;
    if (inc && !dec) begin
      step = CNT_INC;
    end else if (dec && !inc) begin
      step = CNT_DEC;
    end
    return step;
  endfunction

endpackage

// File: rtl/regfile_sb_sb_ctrl.sv
// -----------------------------------------------------------------------------
// sb_ctrl
// Per-register scoreboard: one busy bit per architectural register, the
// set/clear arbitration between issue claims and late-result returns, a
// registered count of busy registers and a registered illegal-claim pulse.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   claim_en_i/claim_addr_i issue marks a destination register pending
//   clr_en_i/clr_addr_i     late write port returns a result (clears busy)
//   ra_addr_i/rb_addr_i     read addresses for the two busy lookups
//   ra_busy_o/rb_busy_o     stored busy bit of the addressed register (comb)
//   busy_cnt_o              registered number of busy registers
//   claim_err_o             registered one-cycle pulse on an illegal claim
//
// Claims and clears are single-cycle strobes: a strobe high at a rising edge
// is consumed at that edge; there is no backpressure on either side.
// -----------------------------------------------------------------------------
module sb_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              claim_en_i,
  input  logic [ADDR_W-1:0] claim_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic              ra_busy_o,
  output logic              rb_busy_o,
  output logic [ADDR_W:0]   busy_cnt_o,
  output logic              claim_err_o
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA    = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic      claim_eff;
  logic      clr_eff;
  logic      claim_was_busy;
  logic      clr_was_busy;
  logic      same_addr;
  logic      cnt_inc;
  logic      cnt_dec;
  cnt_step_e step;

  always_comb begin
    // Register 0 is never tracked when it is hard-wired to zero.
    claim_eff      = claim_en_i && !((ZERO_REG != 0) && (claim_addr_i == ZA));
    clr_eff        = clr_en_i && !((ZERO_REG != 0) && (clr_addr_i == ZA));
    claim_was_busy = busy_q[claim_addr_i];
    clr_was_busy   = busy_q[clr_addr_i];
    same_addr      = (claim_addr_i == clr_addr_i);

    // Count tracks real 0->1 and 1->0 transitions only:
    //  - a claim on an already-busy register adds nothing
    //  - a clear of an idle register (e.g. a result returning after reset
    //    dropped its claim) removes nothing
    //  - a claim re-arming the register being cleared is a net no-change
    cnt_inc = claim_eff && !claim_was_busy;
    cnt_dec = clr_eff && clr_was_busy && !(claim_eff && same_addr);

    // Re-claiming a register whose result returns this very cycle is fine;
    // re-claiming one still in flight is an issue-logic bug.
    err_d = claim_eff && claim_was_busy && !(clr_eff && same_addr);

    // Clear first, then set: the claim wins on an address collision.
    busy_d = busy_q;
    if (clr_eff) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (claim_eff) begin
      busy_d[claim_addr_i] = 1'b1;
    end

    step = cnt_step(cnt_inc, cnt_dec);
    cnt_d = cnt_q;
    case (step)
      CNT_INC: cnt_d = cnt_q + (ADDR_W + 1)'(1);
      CNT_DEC: cnt_d = cnt_q - (ADDR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Busy lookups show the stored bit only; same-cycle claims are not bypassed.
  assign ra_busy_o   = busy_q[ra_addr_i];
  assign rb_busy_o   = busy_q[rb_addr_i];
  assign busy_cnt_o  = cnt_q;
  assign claim_err_o = err_q;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// MIPS general-purpose register file for the decode stage: two combinational
// read ports, an early (ALU) and a late (load/MDU) write port with the late
// port taking priority, optional write-first bypass, and a scoreboard of
// registers with an outstanding long-latency result.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   ra_addr/rb_addr          read addresses
//   ra_data/rb_data          read data (comb, bypassed when BYPASS=1)
//   ra_busy/rb_busy          stored scoreboard bit of the addressed register
//   we_e/wa_e/wd_e           early write port
//   we_l/wa_l/wd_l           late write port (also retires the busy bit)
//   claim_en/claim_addr      issue marks a destination register pending
//   busy_cnt                 registered number of busy registers
//   claim_err                registered pulse on a claim of a busy register
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we_e,
  input  logic [ADDR_W-1:0] wa_e,
  input  logic [DATA_W-1:0] wd_e,
  input  logic              we_l,
  input  logic [ADDR_W-1:0] wa_l,
  input  logic [DATA_W-1:0] wd_l,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              claim_err
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA    = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic we_e_eff;
  logic we_l_eff;
  logic ra_zero;
  logic rb_zero;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign we_e_eff = we_e && !((ZERO_REG != 0) && (wa_e == ZA));
  assign we_l_eff = we_l && !((ZERO_REG != 0) && (wa_l == ZA));

  // Late write applied after early write so it overwrites on a collision.
  always_comb begin
    regs_d = regs_q;
    if (we_e_eff) begin
      regs_d[wa_e] = wd_e;
    end
    if (we_l_eff) begin
      regs_d[wa_l] = wd_l;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // Priority: reset, zero register, late-write bypass, early-write bypass,
  // stored value. The reset term keeps a write presented during reset from
  // leaking through the bypass path.
  // ---------------------------------------------------------------------------
  assign ra_zero = (ZERO_REG != 0) && (ra_addr == ZA);
  assign rb_zero = (ZERO_REG != 0) && (rb_addr == ZA);

  always_comb begin
    ra_data = regs_q[ra_addr];
    if (!rst || ra_zero) begin
      ra_data = '0;
    end else if ((BYPASS != 0) && we_l_eff && (wa_l == ra_addr)) begin
      ra_data = wd_l;
    end else if ((BYPASS != 0) && we_e_eff && (wa_e == ra_addr)) begin
      ra_data = wd_e;
    end
  end

  always_comb begin
    rb_data = regs_q[rb_addr];
    if (!rst || rb_zero) begin
      rb_data = '0;
    end else if ((BYPASS != 0) && we_l_eff && (wa_l == rb_addr)) begin
      rb_data = wd_l;
    end else if ((BYPASS != 0) && we_e_eff && (wa_e == rb_addr)) begin
      rb_data = wd_e;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: only the late port retires a pending result.
  // ---------------------------------------------------------------------------
  sb_ctrl #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .claim_en_i  (claim_en),
    .claim_addr_i(claim_addr),
    .clr_en_i    (we_l),
    .clr_addr_i  (wa_l),
    .ra_addr_i   (ra_addr),
    .rb_addr_i   (rb_addr),
    .ra_busy_o   (ra_busy),
    .rb_busy_o   (rb_busy),
    .busy_cnt_o  (busy_cnt),
    .claim_err_o (claim_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic [AW-1:0] ra_addr, rb_addr, wa_e, wa_l, claim_addr;
  logic          we_e, we_l, claim_en;
  logic [DW-1:0] wd_e, wd_l;

  logic [DW-1:0] ra_data, rb_data, nb_ra_data, nb_rb_data;
  logic          ra_busy, rb_busy, nb_ra_busy, nb_rb_busy;
  logic [AW:0]   busy_cnt, nb_busy_cnt;
  logic          claim_err, nb_claim_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .ra_busy(ra_busy), .rb_busy(rb_busy),
    .we_e(we_e), .wa_e(wa_e), .wd_e(wd_e),
    .we_l(we_l), .wa_l(wa_l), .wd_l(wd_l),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_cnt(busy_cnt), .claim_err(claim_err)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(nb_ra_data), .rb_data(nb_rb_data),
    .ra_busy(nb_ra_busy), .rb_busy(nb_rb_busy),
    .we_e(we_e), .wa_e(wa_e), .wd_e(wd_e),
    .we_l(we_l), .wa_l(wa_l), .wd_l(wd_l),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_cnt(nb_busy_cnt), .claim_err(nb_claim_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total;
  int bad;
  logic [31:0] exp_q[$];

  logic [DW-1:0]   m_regs [NREG];
  logic [NREG-1:0] m_busy;
  logic            m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic exp_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=%h exp=<empty queue>", tag, got);
    end else begin
      check_val(tag, got, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_e = 1'b0; wa_e = '0; wd_e = '0;
    we_l = 1'b0; wa_l = '0; wd_l = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic write_e(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_e = 1'b1; wa_e = a; wd_e = d;
  endtask

  task automatic write_l(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_l = 1'b1; wa_l = a; wd_l = d;
  endtask

  task automatic claim(input logic [AW-1:0] a);
    claim_en = 1'b1; claim_addr = a;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && we_l && wa_l == a) return wd_l;
    if (byp && we_e && wa_e == a) return wd_e;
    return m_regs[a];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ra_addr = '0;
    rb_addr = '0;
    idle();

    // Reset state
    #2;
    exp_push(0); exp_pop("rst_ra_data", ra_data);
    exp_push(0); exp_pop("rst_ra_busy", 32'(ra_busy));
    exp_push(0); exp_pop("rst_busy_cnt", 32'(busy_cnt));
    exp_push(0); exp_pop("rst_claim_err", 32'(claim_err));
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Write r5, claim r9, then async reset mid-cycle
    write_e(5, 32'hDEADBEEF); claim(9);
    tick(); idle();
    ra_addr = 5; rb_addr = 9;
    #1;
    exp_push(32'hDEADBEEF); exp_pop("r5_written", ra_data);
    exp_push(1); exp_pop("r9_claim_cnt", 32'(busy_cnt));
    exp_push(1); exp_pop("r9_claim_busy", 32'(rb_busy));
    #2;
    rst = 1'b0;
    write_e(5, 32'hCAFEF00D);
    #1;
    exp_push(0); exp_pop("async_rst_ra_data", ra_data);
    exp_push(0); exp_pop("async_rst_cnt", 32'(busy_cnt));
    exp_push(0); exp_pop("async_rst_busy", 32'(rb_busy));
    idle();
    #1;
    rst = 1'b1;
    tick();
    exp_push(0); exp_pop("r5_after_rst", ra_data);

    // Late write to r9 whose claim was dropped by reset: no decrement
    write_l(9, 32'h77);
    tick(); idle(); #1;
    exp_push(0); exp_pop("stale_clr_cnt", 32'(busy_cnt));
    exp_push(32'h77); exp_pop("stale_clr_data", rb_data);

    // Write collision: late port wins
    write_e(7, 32'h11111111); write_l(7, 32'h22222222);
    tick(); idle();
    ra_addr = 7;
    #1;
    exp_push(32'h22222222); exp_pop("collision_r7", ra_data);

    // Bypass
    write_e(3, 32'h0BADF00D);
    tick();
    write_e(3, 32'hA5A5A5A5);
    ra_addr = 3;
    #1;
    exp_push(32'hA5A5A5A5); exp_pop("bypass_early", ra_data);
    exp_push(32'h0BADF00D); exp_pop("nobypass_old", nb_ra_data);
    write_l(3, 32'h5A5A5A5A);
    #1;
    exp_push(32'h5A5A5A5A); exp_pop("bypass_late_prio", ra_data);
    tick(); idle(); #1;
    exp_push(32'h5A5A5A5A); exp_pop("r3_stored", ra_data);

    // Scoreboard sequence on r9
    claim(9);
    tick(); idle();
    rb_addr = 9;
    #1;
    exp_push(1); exp_pop("sb_claim_busy", 32'(rb_busy));
    exp_push(1); exp_pop("sb_claim_cnt", 32'(busy_cnt));
    write_l(9, 32'h1234);
    tick(); idle(); #1;
    exp_push(0); exp_pop("sb_clr_busy", 32'(rb_busy));
    exp_push(0); exp_pop("sb_clr_cnt", 32'(busy_cnt));
    exp_push(32'h1234); exp_pop("sb_clr_data", rb_data);
    claim(9);
    tick();
    claim(9); write_l(9, 32'h5678);
    #1;
    exp_push(1); exp_pop("sb_reclaim_pre_busy", 32'(rb_busy));
    tick(); idle(); #1;
    exp_push(1); exp_pop("sb_reclaim_busy", 32'(rb_busy));
    exp_push(1); exp_pop("sb_reclaim_cnt", 32'(busy_cnt));
    exp_push(0); exp_pop("sb_reclaim_err", 32'(claim_err));
    exp_push(32'h5678); exp_pop("sb_reclaim_data", rb_data);
    write_l(9, 32'h0);
    tick(); idle(); #1;
    exp_push(0); exp_pop("sb_final_cnt", 32'(busy_cnt));

    // Illegal claims
    claim(4);
    tick();
    claim(4);
    tick(); idle(); #1;
    exp_push(1); exp_pop("illegal_err_hi", 32'(claim_err));
    exp_push(1); exp_pop("illegal_cnt", 32'(busy_cnt));
    tick();
    exp_push(0); exp_pop("illegal_err_lo", 32'(claim_err));
    claim(0);
    tick(); idle();
    rb_addr = 0;
    #1;
    exp_push(0); exp_pop("r0_claim_err", 32'(claim_err));
    exp_push(1); exp_pop("r0_claim_cnt", 32'(busy_cnt));
    exp_push(0); exp_pop("r0_claim_busy", 32'(rb_busy));
    write_l(4, 32'h0);
    tick(); idle(); #1;
    exp_push(0); exp_pop("r4_clr_cnt", 32'(busy_cnt));

    // Zero register
    write_e(0, 32'hFFFFFFFF); write_l(0, 32'hFFFFFFFF);
    ra_addr = 0;
    #1;
    exp_push(0); exp_pop("r0_bypass", ra_data);
    tick(); idle(); #1;
    exp_push(0); exp_pop("r0_stored", ra_data);

    // Count range: claim r1..r31, then retire them
    for (int i = 1; i < NREG; i++) begin
      claim(AW'(i));
      tick();
      exp_push(32'(i)); exp_pop("fill_cnt", 32'(busy_cnt));
    end
    claim(31);
    tick(); idle(); #1;
    exp_push(1); exp_pop("full_reclaim_err", 32'(claim_err));
    exp_push(31); exp_pop("full_cnt", 32'(busy_cnt));
    for (int i = 1; i < NREG; i++) begin
      write_l(AW'(i), 32'(i));
      tick();
      exp_push(32'(NREG - 1 - i)); exp_pop("drain_cnt", 32'(busy_cnt));
    end
    write_l(5, 32'h5);
    tick(); idle(); #1;
    exp_push(0); exp_pop("empty_clr_cnt", 32'(busy_cnt));

    // Randomised traffic against a reference model
    #2;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_busy = '0;
    tick();
    for (int n = 0; n < 400; n++) begin
      we_e = 1'($urandom_range(0, 1));
      wa_e = AW'($urandom_range(0, 7));
      wd_e = $urandom;
      we_l = 1'($urandom_range(0, 1));
      wa_l = AW'($urandom_range(0, 7));
      wd_l = $urandom;
      claim_en = 1'($urandom_range(0, 1));
      claim_addr = AW'($urandom_range(0, 7));
      ra_addr = AW'($urandom_range(0, 7));
      rb_addr = AW'($urandom_range(0, 7));
      #1;
      exp_push(exp_read(ra_addr, 1'b1)); exp_pop("rnd_ra_data", ra_data);
      exp_push(exp_read(rb_addr, 1'b1)); exp_pop("rnd_rb_data", rb_data);
      exp_push(exp_read(ra_addr, 1'b0)); exp_pop("rnd_nb_ra_data", nb_ra_data);
      exp_push(exp_read(rb_addr, 1'b0)); exp_pop("rnd_nb_rb_data", nb_rb_data);
      exp_push(32'(m_busy[ra_addr])); exp_pop("rnd_ra_busy", 32'(ra_busy));
      exp_push(32'(m_busy[rb_addr])); exp_pop("rnd_rb_busy", 32'(rb_busy));
      exp_push(32'(m_busy[ra_addr])); exp_pop("rnd_nb_ra_busy", 32'(nb_ra_busy));
      exp_push(32'(m_busy[rb_addr])); exp_pop("rnd_nb_rb_busy", 32'(nb_rb_busy));

      m_err = claim_en && (claim_addr != 0) && m_busy[claim_addr] &&
              !(we_l && wa_l == claim_addr);
      if (we_e && wa_e != 0) m_regs[wa_e] = wd_e;
      if (we_l && wa_l != 0) m_regs[wa_l] = wd_l;
      if (we_l && wa_l != 0) m_busy[wa_l] = 1'b0;
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      exp_push(32'($countones(m_busy))); exp_push(32'(m_err));
      exp_push(32'($countones(m_busy))); exp_push(32'(m_err));
      tick();
      exp_pop("rnd_busy_cnt", 32'(busy_cnt));
      exp_pop("rnd_claim_err", 32'(claim_err));
      exp_pop("rnd_nb_busy_cnt", 32'(nb_busy_cnt));
      exp_pop("rnd_nb_claim_err", 32'(nb_claim_err));
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
